// File: rtl/instruction_decoder.sv
// Instruction decoder: decodes the program ROM word into sequencer jump requests and
// datapath controls, holds the zero flag and suppresses the stale ROM word after reset.
module instruction_decoder #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             sync_reset_n,
    input  logic [7:0]       pm_data,
    input  logic             alu_zero,
    output logic             jmp,
    output logic             jmp_nz,
    output logic [3:0]       jmp_addr,
    output logic             dont_jmp,
    output logic [7:0]       reg_en,
    output logic [2:0]       src_sel,
    output logic [3:0]       imm,
    output logic             imm_sel,
    output logic [3:0]       alu_func,
    output logic             alu_y_sel,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic {FLUSH = 1'b0, RUN = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [2:0]       flush_cnt, flush_cnt_nxt;
    logic             zero_flag;
    logic [CNT_W-1:0] count;
    logic             active;
    logic             is_alu;

    // Reset gates decode combinationally so a jump presented in the reset cycle is dropped.
    assign active = sync_reset_n && (state == RUN);
    assign is_alu = (pm_data[7:5] == 3'b110);

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state     <= FLUSH;
            flush_cnt <= 3'(FLUSH_CYCLES);
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        if (state == FLUSH) begin
            if (flush_cnt <= 3'd1) begin
                state_nxt = RUN;
            end else begin
                flush_cnt_nxt = flush_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            zero_flag <= 1'b0;
            count     <= '0;
        end else if (state == RUN) begin
            if (is_alu) begin
                zero_flag <= alu_zero;
            end
            if (count != '1) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign dont_jmp    = zero_flag;
    assign instr_count = count;

    always_comb begin
        jmp       = 1'b0;
        jmp_nz    = 1'b0;
        jmp_addr  = 4'h0;
        reg_en    = 8'h00;
        src_sel   = 3'd0;
        imm       = 4'h0;
        imm_sel   = 1'b0;
        alu_func  = 4'h0;
        alu_y_sel = 1'b0;
        if (active) begin
            casez (pm_data)
                8'b0???_????: begin
                    reg_en  = 8'b1 << pm_data[6:4];
                    imm     = pm_data[3:0];
                    imm_sel = 1'b1;
                end
                8'b10??_????: begin
                    reg_en  = 8'b1 << pm_data[5:3];
                    src_sel = pm_data[2:0];
                end
                8'b110?_????: begin
                    reg_en    = 8'h20;
                    alu_func  = pm_data[3:0];
                    alu_y_sel = pm_data[4];
                end
                8'b1110_????: begin
                    jmp      = 1'b1;
                    jmp_addr = pm_data[3:0];
                end
                default: begin
                    jmp_nz   = 1'b1;
                    jmp_addr = pm_data[3:0];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboard bench for instruction_decoder: a reference model pushes expected outputs
// per driven cycle; they are popped and compared shortly after the inputs settle.
module tb_instruction_decoder;

    logic        clk = 1'b0;
    logic        sync_reset_n;
    logic [7:0]  pm_data;
    logic        alu_zero;
    logic        jmp, jmp_nz, dont_jmp, imm_sel, alu_y_sel;
    logic [3:0]  jmp_addr, imm, alu_func;
    logic [7:0]  reg_en;
    logic [2:0]  src_sel;
    logic [15:0] instr_count;
    logic        n_jmp, n_jmp_nz, n_dont_jmp, n_imm_sel, n_alu_y_sel;
    logic [3:0]  n_jmp_addr, n_imm, n_alu_func;
    logic [7:0]  n_reg_en;
    logic [2:0]  n_src_sel;
    logic [3:0]  n_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_decoder #(.FLUSH_CYCLES(1), .CNT_W(16)) dut (
        .clk(clk), .sync_reset_n(sync_reset_n), .pm_data(pm_data), .alu_zero(alu_zero),
        .jmp(jmp), .jmp_nz(jmp_nz), .jmp_addr(jmp_addr), .dont_jmp(dont_jmp),
        .reg_en(reg_en), .src_sel(src_sel), .imm(imm), .imm_sel(imm_sel),
        .alu_func(alu_func), .alu_y_sel(alu_y_sel), .instr_count(instr_count)
    );

    instruction_decoder #(.FLUSH_CYCLES(1), .CNT_W(4)) dut_narrow (
        .clk(clk), .sync_reset_n(sync_reset_n), .pm_data(pm_data), .alu_zero(alu_zero),
        .jmp(n_jmp), .jmp_nz(n_jmp_nz), .jmp_addr(n_jmp_addr), .dont_jmp(n_dont_jmp),
        .reg_en(n_reg_en), .src_sel(n_src_sel), .imm(n_imm), .imm_sel(n_imm_sel),
        .alu_func(n_alu_func), .alu_y_sel(n_alu_y_sel), .instr_count(n_count)
    );

    typedef struct {
        logic        jmp, jmp_nz, dont_jmp, imm_sel, alu_y_sel;
        logic [3:0]  jmp_addr, imm, alu_func;
        logic [7:0]  reg_en;
        logic [2:0]  src_sel;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t q[$];

    // reference model state
    bit m_run  = 1'b0;
    int m_fcnt = 1;
    bit m_zf   = 1'b0;
    int m_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t pm=%02h)", tag, got, exp, $time, pm_data);
        end
    endtask

    function automatic exp_t predict(input logic [7:0] pm, input bit rst_n);
        exp_t e;
        e = '{default: '0};
        e.dont_jmp = m_zf;
        e.cnt      = 16'(m_cnt);
        e.cnt4     = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
        if (rst_n && m_run) begin
            if (!pm[7]) begin
                e.reg_en = 8'(1 << int'(pm[6:4]));
                e.imm = pm[3:0];
                e.imm_sel = 1'b1;
            end else if (!pm[6]) begin
                e.reg_en = 8'(1 << int'(pm[5:3]));
                e.src_sel = pm[2:0];
            end else if (!pm[5]) begin
                e.reg_en = 8'h20;
                e.alu_func = pm[3:0];
                e.alu_y_sel = pm[4];
            end else begin
                e.jmp = !pm[4];
                e.jmp_nz = pm[4];
                e.jmp_addr = pm[3:0];
            end
        end
        return e;
    endfunction

    task automatic step(input logic [7:0] pm, input bit az, input bit rst_n);
        exp_t e;
        @(negedge clk);
        pm_data = pm;
        alu_zero = az;
        sync_reset_n = rst_n;
        q.push_back(predict(pm, rst_n));
        #1;
        if (q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            chk("jmp", 32'(jmp), 32'(e.jmp));
            chk("jmp_nz", 32'(jmp_nz), 32'(e.jmp_nz));
            chk("jmp_addr", 32'(jmp_addr), 32'(e.jmp_addr));
            chk("dont_jmp", 32'(dont_jmp), 32'(e.dont_jmp));
            chk("reg_en", 32'(reg_en), 32'(e.reg_en));
            chk("src_sel", 32'(src_sel), 32'(e.src_sel));
            chk("imm", 32'(imm), 32'(e.imm));
            chk("imm_sel", 32'(imm_sel), 32'(e.imm_sel));
            chk("alu_func", 32'(alu_func), 32'(e.alu_func));
            chk("alu_y_sel", 32'(alu_y_sel), 32'(e.alu_y_sel));
            chk("instr_count", 32'(instr_count), 32'(e.cnt));
            chk("count_w4", 32'(n_count), 32'(e.cnt4));
            chk("narrow_jmp", 32'(n_jmp), 32'(e.jmp));
        end
        @(posedge clk);
        if (!rst_n) begin
            m_run = 1'b0; m_fcnt = 1; m_zf = 1'b0; m_cnt = 0;
        end else if (!m_run) begin
            if (m_fcnt <= 1) m_run = 1'b1;
            else m_fcnt--;
        end else begin
            if (pm[7:5] == 3'b110) m_zf = az;
            m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
        end
    endtask

    initial begin
        sync_reset_n = 1'b0;
        pm_data = 8'h00;
        alu_zero = 1'b0;
        // first edge brings the DUT out of X; checking starts afterwards
        @(posedge clk);
        step(8'hE5, 0, 0);
        // reset release with a jump held: one flush cycle then jump
        step(8'hE5, 0, 1);
        step(8'hE5, 0, 1);
        chk("plan_jmp", 32'(jmp), 32'd1);
        chk("plan_jaddr", 32'(jmp_addr), 32'h5);
        step(8'hE5, 0, 1);
        chk("plan_cnt1", 32'(instr_count), 32'd1);
        // load immediate and move
        step(8'h3A, 0, 1);
        step(8'h9D, 1, 1);
        // ALU then jnz, both flag polarities
        step(8'hD3, 1, 1);
        step(8'hF2, 0, 1);
        chk("plan_dj1", 32'(dont_jmp), 32'd1);
        step(8'hD3, 0, 1);
        step(8'hF2, 1, 1);
        chk("plan_dj0", 32'(dont_jmp), 32'd0);
        // move between ALU and jnz with alu_zero toggling
        step(8'hC7, 1, 1);
        step(8'h81, 0, 1);
        step(8'h81, 1, 1);
        step(8'h81, 0, 1);
        step(8'hF9, 0, 1);
        // reset with a jump pending, then recovery
        step(8'hE7, 1, 0);
        step(8'hE7, 1, 1);
        chk("rst_dj", 32'(dont_jmp), 32'd0);
        chk("rst_cnt", 32'(instr_count), 32'd0);
        chk("rst_flush_jmp", 32'(jmp), 32'd0);
        step(8'hE7, 1, 1);
        // long run: narrow counter saturates, random instructions exercise every class
        for (int i = 0; i < 40; i++) begin
            step(8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), 1);
        end
        chk("sat_w4", 32'(n_count), 32'hF);
        for (int i = 0; i < 4; i++) begin
            step(8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), bit'(i != 1));
        end
        if (q.size() != 0) chk("sb_left", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
